// File: rtl/sha_ctrl_pkg.sv
// Shared types for the SHA load sequencer: timer command codes, FSM states
// and a small helper used to size the word counters.
package sha_ctrl_pkg;

  // Commands understood by the shift-count timer. Any code with bit 2 set
  // freezes the timer; the low bits only tell a waveform reader which phase
  // the hold belongs to.
  typedef enum logic [2:0] {
    CS_CLEAR    = 3'b000,
    CS_MID      = 3'b001,
    CS_REM      = 3'b010,
    CS_HOLD     = 3'b100,
    CS_HOLD_MID = 3'b101,
    CS_HOLD_REM = 3'b110
  } ctrl_cmd_e;

  typedef enum logic [2:0] {
    IDLE,
    LOAD_MID,
    CLR_MID,
    LOAD_REM,
    RUN,
    DONE
  } seq_state_e;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/sha_load_sequencer_if.sv
// Bundle of every job, word-stream, timer and hash-core signal around the
// sequencer. The sequencer uses the slave view; its surroundings use master.
interface sha_load_sequencer_if
  import sha_ctrl_pkg::*;
#(
  parameter int DATA_W = 32
);
  logic              start;
  logic              abort;
  logic              in_valid;
  logic [DATA_W-1:0] in_data;
  logic              in_ready;
  logic [DATA_W-1:0] shift_data;
  logic              mid_shift_en;
  logic              rem_shift_en;
  ctrl_cmd_e         controller_state;
  logic              midstate_shifts_done;
  logic              remaining_shifts_done;
  logic              core_start;
  logic              core_done;
  logic              job_valid;
  logic              job_ack;
  logic              busy;
  logic              err_timeout;
  logic              err_seq;

  modport master (
    output start, abort, in_valid, in_data, midstate_shifts_done,
           remaining_shifts_done, core_done, job_ack,
    input  in_ready, shift_data, mid_shift_en, rem_shift_en, controller_state,
           core_start, job_valid, busy, err_timeout, err_seq
  );

  modport slave (
    input  start, abort, in_valid, in_data, midstate_shifts_done,
           remaining_shifts_done, core_done, job_ack,
    output in_ready, shift_data, mid_shift_en, rem_shift_en, controller_state,
           core_start, job_valid, busy, err_timeout, err_seq
  );

endinterface

// File: rtl/stall_watchdog.sv
// Counts consecutive idle load cycles. limit_hit fires combinationally on
// the tick that would complete STALL_LIMIT idle cycles, so the caller can
// abort in that very cycle. The count saturates instead of wrapping.
module stall_watchdog #(
  parameter int STALL_LIMIT = 64
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic tick,
  output logic limit_hit
);
  localparam int WD_W = $clog2(STALL_LIMIT + 1);
  localparam logic [WD_W-1:0] LAST_IDLE = WD_W'(STALL_LIMIT - 1);
  localparam logic [WD_W-1:0] TOP_IDLE  = WD_W'(STALL_LIMIT);

  logic [WD_W-1:0] count_q;

  // Idle-cycle counter: clear wins over tick, and it never counts past the limit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else if (clear) begin
      count_q <= '0;
    end else if (tick && (count_q != TOP_IDLE)) begin
      count_q <= count_q + 1'b1;
    end
  end

  assign limit_hit = tick && (count_q == LAST_IDLE);

endmodule

// File: rtl/sha_load_sequencer.sv
// Sequences one hash job: midstate words, a timer clear, remaining words,
// then a hash-core run. A shadow word count cross-checks the external timer
// and a watchdog aborts loads whose input stream stalls for too long.
module sha_load_sequencer
  import sha_ctrl_pkg::*;
#(
  parameter int DATA_W      = 32,
  parameter int MID_WORDS   = 8,
  parameter int REM_WORDS   = 16,
  parameter int STALL_LIMIT = 64
) (
  input logic                clk,
  input logic                rst,
  sha_load_sequencer_if.slave seq_if
);
  localparam int CNT_W = $clog2(max_int(MID_WORDS, REM_WORDS) + 2);
  localparam logic [CNT_W-1:0] MID_N = CNT_W'(MID_WORDS);
  localparam logic [CNT_W-1:0] REM_N = CNT_W'(REM_WORDS);

  seq_state_e       state_q, state_d;
  logic [CNT_W-1:0] shadow_q, shadow_d;
  logic             err_seq_q, err_seq_d;
  logic             core_start_q, core_start_d;

  ctrl_cmd_e        cmd;
  logic             loading, inMid, phaseDone, atLimit;
  logic             inReady, accept, overrun;
  logic             wdTick, wdClear, wdHit;
  logic [CNT_W-1:0] phaseN;
  logic [DATA_W-1:0] passData;

  // Per-cycle load qualifiers: the ready gate, word acceptance, the overrun
  // case where a word beyond the phase length is offered, and watchdog ticks.
  always_comb begin
    loading   = (state_q == LOAD_MID) || (state_q == LOAD_REM);
    inMid     = (state_q == LOAD_MID);
    phaseDone = inMid ? seq_if.midstate_shifts_done : seq_if.remaining_shifts_done;
    phaseN    = inMid ? MID_N : REM_N;
    atLimit   = (shadow_q == phaseN);
    inReady   = loading && !seq_if.abort && !phaseDone && !atLimit;
    accept    = inReady && seq_if.in_valid;
    overrun   = loading && !seq_if.abort && !phaseDone && atLimit && seq_if.in_valid;
    wdTick    = loading && !seq_if.abort && !phaseDone && !seq_if.in_valid;
    wdClear   = !loading || accept;
  end

  stall_watchdog #(
    .STALL_LIMIT(STALL_LIMIT)
  ) u_watchdog (
    .clk      (clk),
    .rst      (rst),
    .clear    (wdClear),
    .tick     (wdTick),
    .limit_hit(wdHit)
  );

  // Next-state logic and timer command; abort beats phase-done, which beats
  // overrun and watchdog expiry.
  always_comb begin
    state_d      = state_q;
    shadow_d     = shadow_q;
    err_seq_d    = err_seq_q;
    core_start_d = 1'b0;
    cmd          = CS_CLEAR;
    case (state_q)
      IDLE: begin
        if (seq_if.start) begin
          state_d   = LOAD_MID;
          shadow_d  = '0;
          err_seq_d = 1'b0;
        end
      end
      LOAD_MID, LOAD_REM: begin
        if (seq_if.abort || phaseDone) begin
          cmd = CS_HOLD;
        end else if (accept) begin
          cmd = inMid ? CS_MID : CS_REM;
        end else begin
          cmd = inMid ? CS_HOLD_MID : CS_HOLD_REM;
        end
        if (seq_if.abort) begin
          state_d = IDLE;
        end else if (phaseDone) begin
          if (atLimit) begin
            state_d      = inMid ? CLR_MID : RUN;
            core_start_d = !inMid;
          end else begin
            err_seq_d = 1'b1;
            state_d   = IDLE;
          end
        end else if (overrun) begin
          err_seq_d = 1'b1;
          state_d   = IDLE;
        end else if (wdHit) begin
          state_d = IDLE;
        end else if (accept) begin
          shadow_d = shadow_q + 1'b1;
        end
      end
      CLR_MID: begin
        shadow_d = '0;
        state_d  = seq_if.abort ? IDLE : LOAD_REM;
      end
      RUN: begin
        if (seq_if.abort) begin
          state_d = IDLE;
        end else if (seq_if.core_done) begin
          state_d = DONE;
        end
      end
      DONE: begin
        cmd = CS_HOLD;
        if (seq_if.abort || seq_if.job_ack) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State, shadow count, sticky sequence error and the core start pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      shadow_q     <= '0;
      err_seq_q    <= 1'b0;
      core_start_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      shadow_q     <= shadow_d;
      err_seq_q    <= err_seq_d;
      core_start_q <= core_start_d;
    end
  end

  assign passData                = seq_if.in_data;
  assign seq_if.shift_data       = passData;
  assign seq_if.in_ready         = inReady;
  assign seq_if.mid_shift_en     = accept && inMid;
  assign seq_if.rem_shift_en     = accept && (state_q == LOAD_REM);
  assign seq_if.controller_state = cmd;
  assign seq_if.core_start       = core_start_q;
  assign seq_if.job_valid        = (state_q == DONE);
  assign seq_if.busy             = (state_q != IDLE);
  assign seq_if.err_timeout      = wdHit;
  assign seq_if.err_seq          = err_seq_q;

endmodule

// File: tb/tb_sha_load_sequencer.sv
// Directed bench for sha_load_sequencer with a behavioural shift-count timer.
module tb_sha_load_sequencer;
  import sha_ctrl_pkg::*;

  logic clk;
  logic rst;
  logic forceMid;
  int   tcount;
  int   midShifts;
  int   remShifts;
  int   nCompared;
  int   nMismatch;

  sha_load_sequencer_if #(.DATA_W(32)) seqIf ();

  sha_load_sequencer #(
    .DATA_W     (32),
    .MID_WORDS  (8),
    .REM_WORDS  (16),
    .STALL_LIMIT(64)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .seq_if(seqIf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Timer model: clear on 000, count on 001/010, hold on any 1xx code.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      tcount <= 0;
    end else begin
      case (seqIf.controller_state)
        3'b000:         tcount <= 0;
        3'b001, 3'b010: tcount <= tcount + 1;
        default:        tcount <= tcount;
      endcase
    end
  end

  assign seqIf.midstate_shifts_done  = (tcount == 8) || (forceMid && (tcount == 5));
  assign seqIf.remaining_shifts_done = (tcount == 16);

  // Running totals of shift enables, sampled mid-cycle.
  always @(negedge clk) begin
    if (seqIf.mid_shift_en) midShifts <= midShifts + 1;
    if (seqIf.rem_shift_en) remShifts <= remShifts + 1;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic s, input logic a, input logic v,
                               input logic [31:0] d, input logic cd, input logic ja);
    seqIf.start     = s;
    seqIf.abort     = a;
    seqIf.in_valid  = v;
    seqIf.in_data   = d;
    seqIf.core_done = cd;
    seqIf.job_ack   = ja;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    nCompared++;
    assert (observed === expected) else begin
      nMismatch++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  // From IDLE: start, 8 midstate words, clear, 16 remaining words; returns in the first RUN cycle.
  task automatic loadPhases(input logic [31:0] base);
    applyStimulus(1, 0, 0, 0, 0, 0);
    #1;
    checkOutput("idleCs", seqIf.controller_state, 3'b000);
    checkOutput("idleReady", seqIf.in_ready, 1'b0);
    tick();
    for (int i = 0; i < 8; i++) begin
      applyStimulus(0, 0, 1, base + i, 0, 0);
      #1;
      checkOutput("midCs", seqIf.controller_state, 3'b001);
      checkOutput("midShift", seqIf.mid_shift_en, 1'b1);
      checkOutput("shiftData", seqIf.shift_data, base + i);
      tick();
    end
    applyStimulus(0, 0, 1, base + 8, 0, 0);
    #1;
    checkOutput("midDoneCs", seqIf.controller_state, 3'b100);
    checkOutput("midDoneReady", seqIf.in_ready, 1'b0);
    checkOutput("midDoneShift", seqIf.mid_shift_en, 1'b0);
    tick();
    #1;
    checkOutput("clrCs", seqIf.controller_state, 3'b000);
    checkOutput("clrReady", seqIf.in_ready, 1'b0);
    tick();
    for (int i = 0; i < 16; i++) begin
      applyStimulus(0, 0, 1, base + 8 + i, 0, 0);
      #1;
      checkOutput("remCs", seqIf.controller_state, 3'b010);
      checkOutput("remShift", seqIf.rem_shift_en, 1'b1);
      checkOutput("remCoreStart", seqIf.core_start, 1'b0);
      tick();
    end
    applyStimulus(0, 0, 0, 0, 0, 0);
    #1;
    checkOutput("remDoneCs", seqIf.controller_state, 3'b100);
    checkOutput("remDoneShift", seqIf.rem_shift_en, 1'b0);
    tick();
  endtask

  // Whole job from IDLE through DONE and acknowledge, back to IDLE.
  task automatic runJob(input logic [31:0] base);
    int m0;
    int r0;
    m0 = midShifts;
    r0 = remShifts;
    loadPhases(base);
    #1;
    checkOutput("runCoreStart", seqIf.core_start, 1'b1);
    checkOutput("runCs", seqIf.controller_state, 3'b000);
    checkOutput("runBusy", seqIf.busy, 1'b1);
    tick();
    #1;
    checkOutput("coreStartOnce", seqIf.core_start, 1'b0);
    checkOutput("runJobValid", seqIf.job_valid, 1'b0);
    applyStimulus(0, 0, 0, 0, 1, 0);
    tick();
    applyStimulus(1, 0, 0, 0, 0, 0);
    #1;
    checkOutput("doneJobValid", seqIf.job_valid, 1'b1);
    checkOutput("doneCs", seqIf.controller_state, 3'b100);
    tick();
    applyStimulus(0, 0, 0, 0, 0, 1);
    #1;
    checkOutput("doneIgnoresStart", seqIf.job_valid, 1'b1);
    tick();
    applyStimulus(0, 0, 0, 0, 0, 0);
    #1;
    checkOutput("ackBusy", seqIf.busy, 1'b0);
    checkOutput("ackJobValid", seqIf.job_valid, 1'b0);
    checkOutput("ackCs", seqIf.controller_state, 3'b000);
    checkOutput("midShiftTotal", midShifts - m0, 8);
    checkOutput("remShiftTotal", remShifts - r0, 16);
  endtask

  initial begin
    nCompared = 0;
    nMismatch = 0;
    midShifts = 0;
    remShifts = 0;
    forceMid  = 1'b0;
    rst       = 1'b1;
    applyStimulus(0, 0, 0, 0, 0, 0);

    $display("[TB] reset state");
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rstCs", seqIf.controller_state, 3'b000);
    checkOutput("rstReady", seqIf.in_ready, 1'b0);
    checkOutput("rstBusy", seqIf.busy, 1'b0);
    checkOutput("rstJobValid", seqIf.job_valid, 1'b0);
    checkOutput("rstCoreStart", seqIf.core_start, 1'b0);
    checkOutput("rstErrSeq", seqIf.err_seq, 1'b0);
    checkOutput("rstErrTimeout", seqIf.err_timeout, 1'b0);
    rst = 1'b0;
    tick();

    $display("[TB] happy path");
    runJob(32'hA000_0000);

    $display("[TB] midstate stall then remaining-phase watchdog");
    applyStimulus(1, 0, 0, 0, 0, 0);
    tick();
    for (int i = 0; i < 4; i++) begin
      applyStimulus(0, 0, 1, 32'hC000_0000 + i, 0, 0);
      #1;
      checkOutput("stallPreCs", seqIf.controller_state, 3'b001);
      tick();
    end
    for (int i = 0; i < 3; i++) begin
      applyStimulus(0, 0, 0, 0, 0, 0);
      #1;
      checkOutput("stallCs", seqIf.controller_state, 3'b101);
      checkOutput("stallShift", seqIf.mid_shift_en, 1'b0);
      checkOutput("stallTimeout", seqIf.err_timeout, 1'b0);
      tick();
    end
    for (int i = 4; i < 8; i++) begin
      applyStimulus(0, 0, 1, 32'hC000_0000 + i, 0, 0);
      #1;
      checkOutput("stallPostCs", seqIf.controller_state, 3'b001);
      tick();
    end
    applyStimulus(0, 0, 0, 0, 0, 0);
    #1;
    checkOutput("stallMidDoneCs", seqIf.controller_state, 3'b100);
    tick();
    #1;
    checkOutput("stallClrCs", seqIf.controller_state, 3'b000);
    tick();
    for (int i = 0; i < 5; i++) begin
      applyStimulus(0, 0, 1, 32'hD000_0000 + i, 0, 0);
      #1;
      checkOutput("wdRemCs", seqIf.controller_state, 3'b010);
      tick();
    end
    applyStimulus(0, 0, 0, 0, 0, 0);
    for (int i = 1; i <= 64; i++) begin
      #1;
      checkOutput("wdTimeout", seqIf.err_timeout, (i == 64));
      checkOutput("wdHoldCs", seqIf.controller_state, 3'b110);
      tick();
    end
    #1;
    checkOutput("wdIdleBusy", seqIf.busy, 1'b0);
    checkOutput("wdIdleCs", seqIf.controller_state, 3'b000);
    checkOutput("wdIdleTimeout", seqIf.err_timeout, 1'b0);
    checkOutput("wdIdleErrSeq", seqIf.err_seq, 1'b0);

    $display("[TB] sequence error");
    forceMid = 1'b1;
    applyStimulus(1, 0, 0, 0, 0, 0);
    tick();
    for (int i = 0; i < 5; i++) begin
      applyStimulus(0, 0, 1, 32'hE000_0000 + i, 0, 0);
      #1;
      checkOutput("seqCs", seqIf.controller_state, 3'b001);
      tick();
    end
    applyStimulus(0, 0, 1, 32'hE000_0005, 0, 0);
    #1;
    checkOutput("seqDoneCs", seqIf.controller_state, 3'b100);
    checkOutput("seqDoneReady", seqIf.in_ready, 1'b0);
    tick();
    applyStimulus(0, 0, 0, 0, 0, 0);
    #1;
    checkOutput("seqErr", seqIf.err_seq, 1'b1);
    checkOutput("seqBusy", seqIf.busy, 1'b0);
    checkOutput("seqCoreStart", seqIf.core_start, 1'b0);
    tick();
    tick();
    #1;
    checkOutput("seqErrSticky", seqIf.err_seq, 1'b1);
    forceMid = 1'b0;
    applyStimulus(1, 0, 0, 0, 0, 0);
    tick();
    applyStimulus(0, 0, 0, 0, 0, 0);
    #1;
    checkOutput("seqErrCleared", seqIf.err_seq, 1'b0);
    checkOutput("seqRestartBusy", seqIf.busy, 1'b1);

    $display("[TB] abort during remaining phase");
    for (int i = 0; i < 8; i++) begin
      applyStimulus(0, 0, 1, 32'hF000_0000 + i, 0, 0);
      #1;
      checkOutput("abMidCs", seqIf.controller_state, 3'b001);
      tick();
    end
    applyStimulus(0, 0, 0, 0, 0, 0);
    tick();
    tick();
    for (int i = 0; i < 10; i++) begin
      applyStimulus(0, 0, 1, 32'hF100_0000 + i, 0, 0);
      #1;
      checkOutput("abRemShift", seqIf.rem_shift_en, 1'b1);
      tick();
    end
    applyStimulus(0, 1, 1, 32'hF100_000A, 0, 0);
    #1;
    checkOutput("abCycleReady", seqIf.in_ready, 1'b0);
    checkOutput("abCycleShift", seqIf.rem_shift_en, 1'b0);
    tick();
    applyStimulus(0, 0, 0, 0, 0, 0);
    #1;
    checkOutput("abIdleBusy", seqIf.busy, 1'b0);
    checkOutput("abIdleCs", seqIf.controller_state, 3'b000);
    checkOutput("abIdleReady", seqIf.in_ready, 1'b0);
    runJob(32'h1234_0000);

    $display("[TB] reset in RUN");
    loadPhases(32'h5500_0000);
    #1;
    checkOutput("preRstCoreStart", seqIf.core_start, 1'b1);
    #2;
    rst = 1'b1;
    #1;
    checkOutput("midRstCs", seqIf.controller_state, 3'b000);
    checkOutput("midRstJobValid", seqIf.job_valid, 1'b0);
    checkOutput("midRstCoreStart", seqIf.core_start, 1'b0);
    checkOutput("midRstBusy", seqIf.busy, 1'b0);
    #1;
    rst = 1'b0;
    tick();
    #1;
    checkOutput("postRstBusy", seqIf.busy, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatch);
    $finish;
  end

endmodule
